// File: rtl/isqrt_seq.sv
// Sequential integer square root y = floor(sqrt(x)), restoring method, one root bit per clock.
// Optional one-entry request buffer during CALC is enabled by defining ISQRT_SEQ_PENDING_EN.
module isqrt_seq #(
    parameter  int n_in  = 32,
    localparam int n_out = n_in / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [n_in-1:0]  x,
    output logic             y_vld,
    output logic [n_out-1:0] y
);

    localparam int cnt_w = (n_out > 1) ? $clog2(n_out) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [cnt_w-1:0]   cnt;
    logic [n_in-1:0]    xs;
    logic [n_in+1:0]    rem;
    logic [n_out-1:0]   root;
    logic               start;
    logic [n_in-1:0]    start_x;

    logic [n_in+3:0]    trial_rem;
    logic [n_in+3:0]    trial;
    logic               fits;
    logic [n_out-1:0]   root_nxt;

`ifdef ISQRT_SEQ_PENDING_EN
    logic               pend_vld;
    logic [n_in-1:0]    pend_x;

    // A buffered request always goes ahead of one arriving in the same DONE cycle.
    assign start   = (state == IDLE && x_vld) || (state == DONE && (x_vld || pend_vld));
    assign start_x = (state == DONE && pend_vld) ? pend_x : x;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_x   <= '0;
        end else if (state == CALC) begin
            if (x_vld && !pend_vld) begin
                pend_vld <= 1'b1;
                pend_x   <= x;
            end
        end else if (state == DONE && pend_vld) begin
            pend_vld <= x_vld;
            if (x_vld) pend_x <= x;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(state == IDLE && pend_vld));
    end
`else
    assign start   = x_vld && (state == IDLE || state == DONE);
    assign start_x = x;
`endif

    // Bring down the next two radicand bits and try appending a 1 to the root.
    always_comb begin
        trial_rem = {rem, xs[n_in-1 -: 2]};
        trial     = {{(n_out + 2){1'b0}}, root, 2'b01};
        fits      = (trial_rem >= trial);
        root_nxt  = {root[n_out-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xs   <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            y    <= '0;
        end else if (start) begin
            xs   <= start_x;
            rem  <= '0;
            root <= '0;
            cnt  <= cnt_w'(n_out - 1);
        end else if (state == CALC) begin
            xs   <= xs << 2;
            rem  <= fits ? (n_in + 2)'(trial_rem - trial) : (n_in + 2)'(trial_rem);
            root <= root_nxt;
            cnt  <= cnt - cnt_w'(1);
            if (cnt == '0) y <= root_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst so a result is never signalled in a cycle that abandons it.
    always_comb begin
        y_vld = (state == DONE) && !rst;
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: stimulus pushes {expected y, expected cycle}; a monitor pops on every y_vld.
module tb_isqrt_seq;

    typedef struct packed {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x = '0;
    logic        y_vld;
    logic [15:0] y;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    isqrt_seq #(.n_in(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
        .y     (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && y_vld) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_y_vld: cycle %0d y=%h, none expected", cyc, y);
            end else begin
                e = sb.pop_front();
                if (y !== e.y || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: got y=%h at cycle %0d, expected y=%h at cycle %0d",
                             y, cyc, e.y, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_at(input logic [15:0] ey, input int at);
        exp_t e;
        e.y   = ey;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] v);
        x     = v;
        x_vld = 1'b1;
        tick();
        x_vld = 1'b0;
    endtask

    function automatic logic [15:0] sqrt_model(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
        end
        return r;
    endfunction

    logic [31:0] corner_x [5] = '{32'd0, 32'd15, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
    logic [15:0] corner_y [5] = '{16'd0, 16'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE};

    initial begin
        int t;
        logic [31:0] v;

        wait_cycles(3);
        checks++;
        if (y_vld !== 1'b0 || y !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: y_vld=%b y=%h, expected 0 and 0000", y_vld, y);
        end
        rst = 1'b0;
        tick();

        // Basic latency: result only at T+17
        t = cyc;
        expect_at(16'd4, t + 17);
        drive(32'd16);
        wait_cycles(20);

        for (int i = 0; i < 5; i++) begin
            t = cyc;
            expect_at(corner_y[i], t + 17);
            drive(corner_x[i]);
            wait_cycles(18);
        end

        // y holds the last result while idle
        wait_cycles(3);
        checks++;
        if (y !== 16'hFFFE || y_vld !== 1'b0) begin
            errors++;
            $display("FAIL y_hold: y=%h y_vld=%b, expected FFFE and 0", y, y_vld);
        end

        // Back-to-back issue in the y_vld cycle
        t = cyc;
        expect_at(16'd10, t + 17);
        drive(32'd100);
        wait_cycles(16);
        expect_at(16'd12, t + 34);
        drive(32'd144);
        wait_cycles(22);

        // Requests while busy
        t = cyc;
        expect_at(16'd7, t + 17);
        drive(32'd49);
        wait_cycles(3);
`ifdef ISQRT_SEQ_PENDING_EN
        expect_at(16'd9, t + 34);
`endif
        drive(32'd81);
        drive(32'd4);
        wait_cycles(45);

        // Reset mid-CALC abandons the operation; x_vld in the reset cycle is ignored
        t = cyc;
        drive(32'd64);
        wait_cycles(7);
        rst   = 1'b1;
        x     = 32'd25;
        x_vld = 1'b1;
        tick();
        rst   = 1'b0;
        x_vld = 1'b0;
        tick();
        expect_at(16'd3, t + 27);
        drive(32'd9);
        wait_cycles(25);

        for (int i = 0; i < 200; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            expect_at(sqrt_model(v), cyc + 17);
            drive(v);
            wait_cycles($urandom_range(16, 19));
        end
        wait_cycles(20);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_results: %0d expected results never appeared, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
